// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//   EX-stage controller for a multi-cycle divider. It captures a DIV/DIVU
//   operand pair, holds start to the divider for the whole run, and stalls
//   the pipeline until the divider reports ready. It then latches {HI,LO}.
//   Each EX instruction produces exactly one divider run. A flush cancels the
//   run and drains the divider before the next issue is accepted.
//
// Ports
//   clk           : clock, rising edge
//   rst           : asynchronous reset, active low
//   ex_div_i      : EX holds a valid DIV/DIVU instruction
//   ex_signed_i   : 1 = DIV (signed), 0 = DIVU
//   ex_op1_i      : dividend (rs)
//   ex_op2_i      : divisor (rt)
//   flush_i       : kills the EX instruction
//   stall_i       : downstream stall; the EX instruction does not advance
//   div_ready_i   : divider result valid
//   div_result_i  : divider result {remainder, quotient}
//   div_start_o   : divider start, high for the whole run
//   div_annul_o   : divider cancel
//   div_signed_o  : registered signed flag to the divider
//   div_op1_o     : registered dividend to the divider
//   div_op2_o     : registered divisor to the divider
//   stall_o       : stall request to the pipeline controller (combinational)
//   res_valid_o   : hi_o/lo_o hold the result of the current EX instruction
//   hi_o          : remainder
//   lo_o          : quotient
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int CANCEL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stall_o,
    output logic        res_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = (CANCEL_CYCLES > 1) ? $clog2(CANCEL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        CANCEL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               signed_q, signed_d;
    logic [31:0]        op1_q, op1_d;
    logic [31:0]        op2_q, op2_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               issue;
    logic               capture;

    // A new instruction is accepted only from IDLE; CANCEL ignores ex_div_i.
    assign issue   = (state_q == IDLE) && ex_div_i && !flush_i;
    // A flush in the ready cycle discards the result.
    assign capture = (state_q == WAIT) && !flush_i && div_ready_i;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_d = CANCEL;
                    cnt_d   = CNT_W'(CANCEL_CYCLES - 1);
                end else if (div_ready_i) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Leaving HOLD drops res_valid; staying keeps the result
                // without re-issuing, since start is low here.
                if (flush_i || !stall_i) begin
                    state_d = IDLE;
                end
            end
            CANCEL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Operand and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Operands are frozen from issue until the next issue, so later changes
    // on ex_op*_i cannot disturb a run in progress.
    always_comb begin
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (issue) begin
            signed_d = ex_signed_i;
            op1_d    = ex_op1_i;
            op2_d    = ex_op2_i;
        end
        if (capture) begin
            hi_d = div_result_i[63:32];
            lo_d = div_result_i[31:0];
        end
    end

    // Output decode
    always_comb begin
        div_start_o  = (state_q == WAIT);
        div_annul_o  = (state_q == CANCEL);
        res_valid_o  = (state_q == HOLD);
        div_signed_o = signed_q;
        div_op1_o    = op1_q;
        div_op2_o    = op2_q;
        hi_o         = hi_q;
        lo_o         = lo_q;
        // Stall while a DIV is waiting to issue (including while the
        // divider drains after a flush) and for the whole run.
        stall_o      = issue
                     || (state_q == WAIT)
                     || ((state_q == CANCEL) && ex_div_i && !flush_i);
    end

endmodule
